// File: rtl/fetch_unit_if.sv
// Controller and program-memory signals of the fetch unit, bundled as one interface.
// The slave modport is the fetch unit's view; the master modport is the controller/memory side.
interface fetch_unit_if;
  logic       fetch_req;
  logic       pc_load;
  logic [7:0] pc_load_val;
  logic [7:0] mem_data;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic [7:0] ir;
  logic [7:0] ar;
  logic [7:0] pc;
  logic       ir_valid;
  logic       busy;

  modport slave (
    input  fetch_req, pc_load, pc_load_val, mem_data,
    output mem_addr, mem_rd_en, ir, ar, pc, ir_valid, busy
  );

  modport master (
    output fetch_req, pc_load, pc_load_val, mem_data,
    input  mem_addr, mem_rd_en, ir, ar, pc, ir_valid, busy
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: reads a one- or two-byte instruction into ir/ar from the
// PC and pulses ir_valid once the instruction is complete.
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic          fetch_clk,
  input  logic          fetch_rst,
  fetch_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, FETCH1, FETCH2, VALID} state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] ar_q, ar_d;

  // Opcodes 5..8 carry an address byte after the opcode byte.
  function automatic logic is_two_byte(input logic [3:0] opcode);
    return (opcode == 4'b0101) || (opcode == 4'b0110) ||
           (opcode == 4'b0111) || (opcode == 4'b1000);
  endfunction

  always_ff @(posedge fetch_clk) begin
    if (fetch_rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      ar_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ar_q    <= ar_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    ar_d          = ar_q;
    bus.mem_rd_en = 1'b0;
    bus.mem_addr  = 8'h00;
    bus.ir_valid  = 1'b0;
    bus.busy      = 1'b1;

    case (state_q)
      IDLE: begin
        bus.busy = 1'b0;
        // A branch wins over a fetch request arriving in the same cycle.
        if (bus.pc_load) begin
          pc_d = bus.pc_load_val;
        end else if (bus.fetch_req) begin
          state_d = FETCH1;
        end
      end
      FETCH1: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = pc_q;
        ir_d          = bus.mem_data;
        pc_d          = pc_q + 8'd1;
        if (is_two_byte(bus.mem_data[7:4])) begin
          state_d = FETCH2;
        end else begin
          ar_d    = 8'h00;
          state_d = VALID;
        end
      end
      FETCH2: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = pc_q;
        ar_d          = bus.mem_data;
        pc_d          = pc_q + 8'd1;
        state_d       = VALID;
      end
      VALID: begin
        bus.ir_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ir = ir_q;
  assign bus.ar = ar_q;
  assign bus.pc = pc_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, PC value loaded on reset.
REQ-002 SHALL have port fetch_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port fetch_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port fetch_req  input  1  controller request for next instruction; sampled only in IDLE.
REQ-005 SHALL have port pc_load  input  1  branch request; loads pc_load_val into PC; sampled only in IDLE.
REQ-006 SHALL have port pc_load_val  input  8  branch target address.
REQ-007 SHALL have port mem_data  input  8  read data from program memory, combinational, valid in the same cycle as mem_addr.
REQ-008 SHALL have port mem_addr  output  8  program memory address.
REQ-009 SHALL have port mem_rd_en  output  1  program memory read enable.
REQ-010 SHALL have port ir  output  8  instruction register: opcode[7:4], src[3:2], dest[1:0].
REQ-011 SHALL have port ar  output  8  address register; second instruction byte.
REQ-012 SHALL have port pc  output  8  current program counter.
REQ-013 SHALL have port ir_valid  output  1  one-cycle pulse; ir/ar hold a complete new instruction.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH1, FETCH2, VALID, all registered.
REQ-016 IDLE: mem_rd_en=0, mem_addr=8'h00, busy=0, ir_valid=0.
REQ-017 IDLE with pc_load=1: next PC=pc_load_val, stay IDLE; fetch_req in the same cycle ignored (pc_load has priority).
REQ-018 IDLE with fetch_req=1 and pc_load=0: next state FETCH1.
REQ-019 FETCH1: mem_rd_en=1, mem_addr=pc; at edge ir<=mem_data, pc<=pc+1.
REQ-020 FETCH1 exit: mem_data[7:4] in {4'b0101, 4'b0110, 4'b0111, 4'b1000} -> FETCH2; otherwise -> VALID with ar<=8'h00.
REQ-021 FETCH2: mem_rd_en=1, mem_addr=pc; at edge ar<=mem_data, pc<=pc+1, next VALID.
REQ-022 VALID: ir_valid=1, mem_rd_en=0, mem_addr=8'h00, busy=1; next IDLE unconditionally.
REQ-023 Latency from fetch_req sampled in IDLE (cycle N) to ir_valid: cycle N+2 for one-byte, N+3 for two-byte instructions.
REQ-024 fetch_req and pc_load outside IDLE SHALL be ignored, never queued.
REQ-025 PC arithmetic SHALL be 8-bit modulo; 8'hFF+1 wraps to 8'h00, including between FETCH1 and FETCH2.
REQ-026 ir and ar SHALL hold their values outside FETCH1/FETCH2 updates.
REQ-027 fetch_req held high continuously SHALL produce back-to-back fetches with one IDLE cycle between them.

Reset
REQ-028 On fetch_rst=1 at a rising edge: state=IDLE, pc=RESET_PC, ir=8'h00, ar=8'h00, ir_valid=0, busy=0, mem_rd_en=0, mem_addr=8'h00.
REQ-029 fetch_rst SHALL override all other inputs, including mid-fetch in FETCH1/FETCH2/VALID; the aborted instruction produces no ir_valid.
REQ-030 No output SHALL change asynchronously on fetch_rst assertion.

Verification
REQ-031 Memory [0]=8'h50, [1]=8'h0A; reset, pulse fetch_req -> ir_valid at N+3, ir=8'h50, ar=8'h0A, pc=8'h02.
REQ-032 Memory [4]=8'h11, pc loaded to 8'h04, fetch_req -> ir_valid at N+2, ir=8'h11, ar=8'h00, pc=8'h05.
REQ-033 pc_load=1, pc_load_val=8'h0A, with fetch_req=1 in the same IDLE cycle -> pc=8'h0A, state IDLE, no fetch; next fetch_req reads address 8'h0A.
REQ-034 pc loaded to 8'hFF, memory [FF]=8'h60, [00]=8'h0B -> ir=8'h60, ar=8'h0B, pc=8'h01.
REQ-035 fetch_rst asserted in FETCH2 -> next cycle: all outputs at reset values, no ir_valid pulse; pc_load during FETCH1 has no effect on pc.
